// File: rtl/blackparrot_fpga_host_io_arbiter.sv
// Shares one BlackParrot I/O-in command port between two host requesters
// (0 = NBF loader, 1 = debug/MMIO). Commands are granted round-robin and
// tagged in an in-order tag FIFO; in-order responses are routed back to the
// issuing requester using the tag at the FIFO head.
//
// Ports:
//   m_axi_aclk / m_axi_aresetn   clock, async active-low reset
//   req_*_i / req_ready_and_o    per-requester command channel (2 lanes packed)
//   cmd_*_o / cmd_ready_and_i    shared command port
//   resp_*_i / resp_yumi_o       shared response port
//   req_resp_*                   routed response channel
//   outstanding_o                per-requester in-flight counts (lane 0 in LSBs)
//   idle_o                       tag FIFO empty
//   error_o                      sticky: response arrived with nothing in flight
module blackparrot_fpga_host_io_arbiter #(
  parameter int unsigned addr_width_p      = 64,
  parameter int unsigned data_width_p      = 64,
  parameter int unsigned max_outstanding_p = 8
) (
  input  logic                                             m_axi_aclk,
  input  logic                                             m_axi_aresetn,
  input  logic [1:0]                                       req_v_i,
  input  logic [2*addr_width_p-1:0]                        req_addr_i,
  input  logic [2*data_width_p-1:0]                        req_data_i,
  input  logic [1:0]                                       req_w_i,
  input  logic [2*(data_width_p/8)-1:0]                    req_wmask_i,
  input  logic [5:0]                                       req_size_i,
  output logic [1:0]                                       req_ready_and_o,
  output logic                                             cmd_v_o,
  output logic [addr_width_p-1:0]                          cmd_addr_o,
  output logic [data_width_p-1:0]                          cmd_data_o,
  output logic                                             cmd_w_o,
  output logic [data_width_p/8-1:0]                        cmd_wmask_o,
  output logic [2:0]                                       cmd_size_o,
  input  logic                                             cmd_ready_and_i,
  input  logic                                             resp_v_i,
  input  logic [data_width_p-1:0]                          resp_data_i,
  input  logic                                             resp_w_i,
  output logic                                             resp_yumi_o,
  output logic [1:0]                                       req_resp_v_o,
  output logic [data_width_p-1:0]                          req_resp_data_o,
  output logic                                             req_resp_w_o,
  input  logic [1:0]                                       req_resp_yumi_i,
  output logic [2*$clog2(max_outstanding_p+1)-1:0]         outstanding_o,
  output logic                                             idle_o,
  output logic                                             error_o
);

  localparam int unsigned MaskWidth = data_width_p / 8;
  localparam int unsigned CntWidth  = $clog2(max_outstanding_p + 1);
  localparam int unsigned PtrWidth  = $clog2(max_outstanding_p);

  // Reset is asserted asynchronously but released on the first clock edge;
  // until then all handshakes are held off so no state can move.
  logic rst_sync_q;
  logic active;

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) rst_sync_q <= 1'b0;
    else                rst_sync_q <= 1'b1;
  end

  assign active = rst_sync_q;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                               prio_q, prio_d;
  logic [max_outstanding_p-1:0]       tags_q, tags_d;
  logic [PtrWidth:0]                  wr_ptr_q, wr_ptr_d;
  logic [PtrWidth:0]                  rd_ptr_q, rd_ptr_d;
  logic [1:0][CntWidth-1:0]           cnt_q, cnt_d;
  logic                               error_q, error_d;

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      prio_q   <= 1'b0;
      tags_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      error_q  <= 1'b0;
    end else begin
      prio_q   <= prio_d;
      tags_q   <= tags_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      error_q  <= error_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Tag FIFO status (extra pointer MSB distinguishes full from empty)
  // ---------------------------------------------------------------------------
  logic tag_empty, tag_full, head;

  assign tag_empty = (wr_ptr_q == rd_ptr_q);
  assign tag_full  = (wr_ptr_q[PtrWidth] != rd_ptr_q[PtrWidth]) &&
                     (wr_ptr_q[PtrWidth-1:0] == rd_ptr_q[PtrWidth-1:0]);
  assign head      = tags_q[rd_ptr_q[PtrWidth-1:0]];

  // ---------------------------------------------------------------------------
  // Arbitration and command mux
  // ---------------------------------------------------------------------------
  logic       gnt_id;
  logic [1:0] grant;
  logic       enq, deq;

  always_comb begin
    gnt_id = prio_q;
    if (!req_v_i[prio_q]) gnt_id = ~prio_q;
    grant = 2'b00;
    if (|req_v_i) grant = gnt_id ? 2'b10 : 2'b01;
  end

  assign cmd_v_o         = active & (|(req_v_i & grant)) & ~tag_full;
  assign req_ready_and_o = grant & {2{active & cmd_ready_and_i & ~tag_full}};
  assign enq             = cmd_v_o & cmd_ready_and_i;

  assign cmd_addr_o  = gnt_id ? req_addr_i[2*addr_width_p-1:addr_width_p]
                              : req_addr_i[addr_width_p-1:0];
  assign cmd_data_o  = gnt_id ? req_data_i[2*data_width_p-1:data_width_p]
                              : req_data_i[data_width_p-1:0];
  assign cmd_wmask_o = gnt_id ? req_wmask_i[2*MaskWidth-1:MaskWidth]
                              : req_wmask_i[MaskWidth-1:0];
  assign cmd_w_o     = gnt_id ? req_w_i[1] : req_w_i[0];
  assign cmd_size_o  = gnt_id ? req_size_i[5:3] : req_size_i[2:0];

  // ---------------------------------------------------------------------------
  // Response routing; a response with nothing in flight is swallowed.
  // ---------------------------------------------------------------------------
  logic resp_routed;

  assign resp_routed     = active & resp_v_i & ~tag_empty;
  assign req_resp_v_o    = resp_routed ? (head ? 2'b10 : 2'b01) : 2'b00;
  assign req_resp_data_o = resp_data_i;
  assign req_resp_w_o    = resp_w_i;
  assign resp_yumi_o     = active & resp_v_i & (tag_empty | req_resp_yumi_i[head]);
  assign deq             = resp_yumi_o & ~tag_empty;

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  logic [1:0] inc, dec;

  always_comb begin
    prio_d   = enq ? ~gnt_id : prio_q;
    tags_d   = tags_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (enq) begin
      tags_d[wr_ptr_q[PtrWidth-1:0]] = gnt_id;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (deq) rd_ptr_d = rd_ptr_q + 1'b1;

    error_d = error_q | (active & resp_v_i & tag_empty);

    inc = enq ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    dec = deq ? (head   ? 2'b10 : 2'b01) : 2'b00;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      case ({inc[i], dec[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CntWidth'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CntWidth'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  assign outstanding_o = cnt_q;
  assign idle_o        = tag_empty;
  assign error_o       = error_q;

endmodule

// File: doc/blackparrot_fpga_host_io_arbiter.md
# blackparrot_fpga_host_io_arbiter

Shares the single BlackParrot I/O-in command port (the FIFO-style command/response interface that front-ends the M AXI master) between two host requesters: requester 0 is the NBF loader, requester 1 is the debug/MMIO requester. Commands are granted round-robin. Each accepted command is tagged with its requester ID in an in-order tag FIFO. Responses, which return in command order, are routed back to the issuing requester. Per-requester outstanding counters let each requester implement fences.

## Interface
- `addr_width_p`, 64: command address width.
- `data_width_p`, 64: command and response data width.
- `max_outstanding_p`, 8: tag FIFO depth, i.e. the maximum number of commands in flight. Must be a power of 2 and ≥2.
- `m_axi_aclk` in 1: the block's single clock.
- `m_axi_aresetn` in 1: reset, asynchronous assert, active-low.
- `req_v_i` in 2: per-requester command valid.
- `req_addr_i` in 2×addr_width_p: command address.
- `req_data_i` in 2×data_width_p: write data.
- `req_w_i` in 2: 1 = write, 0 = read.
- `req_wmask_i` in 2×(data_width_p/8): byte write mask.
- `req_size_i` in 2×3: log2 of the byte size.
- `req_ready_and_o` out 2: per-requester command ready; the command is accepted when `req_v_i[i] & req_ready_and_o[i]`.
- `cmd_v_o`, `cmd_addr_o`, `cmd_data_o`, `cmd_w_o`, `cmd_wmask_o`, `cmd_size_o` out: the granted command, driven to the shared port.
- `cmd_ready_and_i` in 1: the shared port accepts the command.
- `resp_v_i` in 1: response valid from the shared port.
- `resp_data_i` in data_width_p: response data.
- `resp_w_i` in 1: 1 = write acknowledge, 0 = read data.
- `resp_yumi_o` out 1: response consumed.
- `req_resp_v_o` out 2: routed response valid, per requester.
- `req_resp_data_o` out data_width_p: response data, shared by both requesters.
- `req_resp_w_o` out 1: response type, shared by both requesters.
- `req_resp_yumi_i` in 2: per-requester response consume.
- `outstanding_o` out 2×clog2(max_outstanding_p+1): per-requester count of commands in flight.
- `idle_o` out 1: high when the tag FIFO is empty.
- `error_o` out 1: sticky error flag.

## Operation
- **Arbitration:**
  - `grant` is one-hot over the requesters with `req_v_i` high.
  - Priority is round-robin: the requester granted last has the lower priority.
  - After reset, requester 0 has priority.
  - The priority pointer advances only on an accepted command (`cmd_v_o & cmd_ready_and_i`).
  - Grant is not locked while a requester's valid is held; an unaccepted grant may move if the other requester becomes the higher-priority valid one. Requesters must hold `req_v_i` and their payload until accepted.
- **Command path:**
  - `cmd_*` mux the granted requester's fields.
  - `cmd_v_o = |(req_v_i & grant) & ~tag_full`.
  - `req_ready_and_o[i] = grant[i] & cmd_ready_and_i & ~tag_full`.
  - When no requester is valid, `cmd_*` payload is don't-care, but `cmd_v_o` must be 0.
- **Tag FIFO:**
  - Depth `max_outstanding_p`, 1-bit entries holding the requester ID.
  - Enqueue on command accept; dequeue on `resp_yumi_o`.
  - Full blocks acceptance even if a dequeue happens in the same cycle (no bypass).
  - Simultaneous enqueue and dequeue when not full leaves the occupancy unchanged.
- **Response routing:**
  - `head` is the tag at the FIFO head.
  - `req_resp_v_o[head] = resp_v_i & ~tag_empty`; the other bit is 0.
  - `req_resp_data_o = resp_data_i`, `req_resp_w_o = resp_w_i`.
  - `resp_yumi_o = req_resp_yumi_i[head] & resp_v_i & ~tag_empty`.
  - A requester's yumi is ignored while its `req_resp_v_o` bit is low.
- **Outstanding counters:**
  - `outstanding_o[i]` increments on accept by i and decrements on dequeue of a tag equal to i.
  - Both in the same cycle for the same i: the count is unchanged.
  - The counters never wrap; the sum of both counters equals the tag FIFO occupancy.
- **Error:**
  - `resp_v_i` while the tag FIFO is empty sets `error_o`.
  - That response is consumed (`resp_yumi_o = 1`) and dropped.
  - `error_o` clears only on reset.

## Timing
- The command path is combinational: zero-cycle latency from request to `cmd_v_o`.
- The response path is combinational: zero-cycle latency from `resp_v_i` to `req_resp_v_o`.
- The priority pointer, tag FIFO, counters, and `error_o` update at the `m_axi_aclk` rising edge.
- Reset values (asserted asynchronously by `m_axi_aresetn` low):
  - Tag FIFO empty, so `idle_o` = 1.
  - `outstanding_o` = 0, `error_o` = 0.
  - Priority pointer on requester 0.
  - `cmd_v_o`, `req_ready_and_o`, `req_resp_v_o`, `resp_yumi_o` = 0 while reset is held.
- Reset mid-operation discards all in-flight tags. The shared port is reset by the same signal, so no stale responses are expected.
- Reset release is synchronized internally: state leaves reset on the first rising edge after deassertion.
- Throughput: one command accepted per cycle and one response routed per cycle, concurrently.

## Test plan
- **Alternation:** both requesters continuously valid, `cmd_ready_and_i` = 1. Required: grants alternate 0,1,0,1 starting with 0 after reset; tag FIFO contents read 0,1,0,1.
- **Single requester:** only requester 1 valid, 3 writes accepted, then 3 write acks returned. Required: `outstanding_o[1]` goes 1,2,3 then 2,1,0; `req_resp_v_o` = 2'b10 for each ack; `idle_o` returns to 1.
- **Full:** with `max_outstanding_p` = 8, issue 8 reads without responses. Required: `req_ready_and_o` = 0 and `cmd_v_o` = 0 on the 9th request. Returning one response in a cycle when full does not accept a new command that cycle; the command is accepted the next cycle.
- **Response routing:** requester 0 issues a read to 0x110000, then requester 1 issues a read to 0x200. Responses return with data 0xAAAA then 0xBBBB. Required: requester 0 sees 0xAAAA, requester 1 sees 0xBBBB. Requester 1 asserting yumi while the head is requester 0 does not dequeue.
- **Spurious response:** assert `resp_v_i` with the tag FIFO empty. Required: `resp_yumi_o` = 1, `error_o` = 1 from the next cycle and held; both `req_resp_v_o` bits stay 0.
- **Reset mid-operation:** assert `m_axi_aresetn` low with 5 commands outstanding. Required: outputs reach their reset values immediately (asynchronously); after release, `idle_o` = 1, both counters are 0, and requester 0 has priority.
